// File: rtl/axi_lite_ptgen_master.sv
// AXI4-Lite master pattern generator: on an INIT rising edge it runs a strided burst of
// single-beat writes and/or reads, checks read data and responses, and counts errors.
module axi_lite_ptgen_master #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_NUM_TXN          = 4,
  parameter logic [63:0] C_BASE_ADDR        = 64'h4000_0000,
  parameter logic [63:0] C_ADDR_STRIDE      = 64'd4,
  parameter logic [31:0] C_SEED             = 32'hA5A5_0000
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            INIT_AXI_TXN,
  input  logic [1:0]                      MODE,
  output logic                            TXN_DONE,
  output logic                            ERROR,
  output logic [7:0]                      ERR_COUNT,
  output logic                            BUSY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int AW    = C_M_AXI_ADDR_WIDTH;
  localparam int DW    = C_M_AXI_DATA_WIDTH;
  localparam int IDX_W = $clog2(C_NUM_TXN + 1);
  localparam logic [AW-1:0]    BASE   = AW'(C_BASE_ADDR);
  localparam logic [AW-1:0]    STRIDE = AW'(C_ADDR_STRIDE);
  localparam logic [DW-1:0]    SEED0  = DW'(C_SEED);
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(C_NUM_TXN - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

  state_t           state;
  logic             init_q;
  logic [1:0]       mode_q;
  logic             active;
  logic             aw_done;
  logic             w_done;
  logic [IDX_W-1:0] idx;
  logic [AW-1:0]    cur_addr;
  logic [DW-1:0]    cur_data;

  logic start, aw_hs, w_hs, b_hs, ar_hs, r_hs, last, err_inc;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign start   = INIT_AXI_TXN & ~init_q & ((state == S_IDLE) | (state == S_DONE));
  assign aw_hs   = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs    = M_AXI_WVALID & M_AXI_WREADY;
  assign b_hs    = M_AXI_BVALID & M_AXI_BREADY;
  assign ar_hs   = M_AXI_ARVALID & M_AXI_ARREADY;
  assign r_hs    = M_AXI_RVALID & M_AXI_RREADY;
  assign last    = (idx == LAST);
  // A read counts at most once even if both response and data are bad.
  assign err_inc = ((state == S_WRITE) & b_hs & (M_AXI_BRESP != 2'b00)) |
                   ((state == S_READ) & r_hs &
                    ((M_AXI_RRESP != 2'b00) | (M_AXI_RDATA != cur_data)));

  assign M_AXI_AWADDR = cur_addr;
  assign M_AXI_ARADDR = cur_addr;
  assign M_AXI_WDATA  = cur_data;
  assign M_AXI_WSTRB  = '1;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= S_IDLE;
      init_q        <= 1'b0;
      mode_q        <= 2'b00;
      active        <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      idx           <= '0;
      cur_addr      <= '0;
      cur_data      <= '0;
      TXN_DONE      <= 1'b0;
      ERROR         <= 1'b0;
      ERR_COUNT     <= 8'd0;
      BUSY          <= 1'b0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      init_q <= INIT_AXI_TXN;
      if (err_inc) begin
        ERR_COUNT <= sat_inc(ERR_COUNT);
        ERROR     <= 1'b1;
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            TXN_DONE  <= 1'b0;
            ERROR     <= 1'b0;
            ERR_COUNT <= 8'd0;
            BUSY      <= 1'b1;
            mode_q    <= MODE;
            active    <= 1'b0;
            idx       <= '0;
            cur_addr  <= BASE;
            cur_data  <= SEED0;
            state     <= (MODE == 2'b10) ? S_READ : S_WRITE;
          end
        end
        S_WRITE: begin
          if (!active) begin
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            active        <= 1'b1;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
          end else begin
            if (aw_hs) begin
              M_AXI_AWVALID <= 1'b0;
              aw_done       <= 1'b1;
            end
            if (w_hs) begin
              M_AXI_WVALID <= 1'b0;
              w_done       <= 1'b1;
            end
            if (b_hs) begin
              M_AXI_BREADY <= 1'b0;
              active       <= 1'b0;
              if (last) begin
                idx      <= '0;
                cur_addr <= BASE;
                cur_data <= SEED0;
                if (mode_q == 2'b01) begin
                  state    <= S_DONE;
                  TXN_DONE <= 1'b1;
                  BUSY     <= 1'b0;
                end else begin
                  state <= S_READ;
                end
              end else begin
                idx      <= idx + 1'b1;
                cur_addr <= cur_addr + STRIDE;
                cur_data <= cur_data + 1'b1;
              end
            end else if ((aw_done | aw_hs) & (w_done | w_hs)) begin
              M_AXI_BREADY <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (!active) begin
            M_AXI_ARVALID <= 1'b1;
            active        <= 1'b1;
          end else begin
            if (ar_hs) begin
              M_AXI_ARVALID <= 1'b0;
              M_AXI_RREADY  <= 1'b1;
            end
            if (r_hs) begin
              M_AXI_RREADY <= 1'b0;
              active       <= 1'b0;
              if (last) begin
                idx      <= '0;
                cur_addr <= BASE;
                cur_data <= SEED0;
                state    <= S_DONE;
                TXN_DONE <= 1'b1;
                BUSY     <= 1'b0;
              end else begin
                idx      <= idx + 1'b1;
                cur_addr <= cur_addr + STRIDE;
                cur_data <= cur_data + 1'b1;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_ptgen_master.sv
// Bench for axi_lite_ptgen_master: reactive AXI4-Lite slave with injectable faults,
// protocol monitor and a transaction-list reference model.
module tb_axi_lite_ptgen_master;

  localparam int          N      = 4;
  localparam logic [31:0] BASE   = 32'h4000_0000;
  localparam logic [31:0] STRIDE = 32'd4;
  localparam logic [31:0] SEED   = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init = 1'b0;
  logic [1:0] mode = 2'b00;

  logic        txn_done, error, busy;
  logic [7:0]  err_count;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;

  axi_lite_ptgen_master dut (
    .ACLK(clk), .ARESETN(rst_n), .INIT_AXI_TXN(init), .MODE(mode),
    .TXN_DONE(txn_done), .ERROR(error), .ERR_COUNT(err_count), .BUSY(busy),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  // Second instance: two transactions starting just below the 32-bit address top.
  logic        init1 = 1'b0;
  logic [1:0]  mode1 = 2'b01;
  logic        txn_done1, error1, busy1;
  logic [7:0]  err_count1;
  logic [31:0] awaddr1, araddr1, wdata1;
  logic [2:0]  awprot1, arprot1;
  logic [3:0]  wstrb1;
  logic awvalid1, wvalid1, bvalid1, bready1, arvalid1, rready1;
  logic        one = 1'b1;
  logic        zero = 1'b0;
  logic [1:0]  okay = 2'b00;
  logic [31:0] zero32 = 32'd0;
  logic [31:0] aw1_q[$];
  logic [31:0] w1_q[$];

  axi_lite_ptgen_master #(
    .C_NUM_TXN(2), .C_BASE_ADDR(64'hFFFF_FFFC), .C_ADDR_STRIDE(64'd4)
  ) dut1 (
    .ACLK(clk), .ARESETN(rst_n), .INIT_AXI_TXN(init1), .MODE(mode1),
    .TXN_DONE(txn_done1), .ERROR(error1), .ERR_COUNT(err_count1), .BUSY(busy1),
    .M_AXI_AWADDR(awaddr1), .M_AXI_AWPROT(awprot1), .M_AXI_AWVALID(awvalid1), .M_AXI_AWREADY(one),
    .M_AXI_WDATA(wdata1), .M_AXI_WSTRB(wstrb1), .M_AXI_WVALID(wvalid1), .M_AXI_WREADY(one),
    .M_AXI_BRESP(okay), .M_AXI_BVALID(bvalid1), .M_AXI_BREADY(bready1),
    .M_AXI_ARADDR(araddr1), .M_AXI_ARPROT(arprot1), .M_AXI_ARVALID(arvalid1), .M_AXI_ARREADY(one),
    .M_AXI_RDATA(zero32), .M_AXI_RRESP(okay), .M_AXI_RVALID(zero), .M_AXI_RREADY(rready1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave knobs and transaction logs
  int aw_dly = 0, w_dly = 0, ar_dly = 0, bad_idx = -1;
  bit rand_inj = 0, bresp_all = 0;
  int aw_cnt, w_cnt, ar_cnt, aw_hs_n, w_hs_n, b_hs_n;
  bit got_aw, got_w, s_aw_now, s_w_now, s_inj, s_rinj;
  logic [31:0] s_d;
  logic [31:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$], r_data_q[$];
  bit b_inj_q[$], r_inj_q[$];
  logic [31:0] mem[logic [31:0]];

  assign awready = awvalid && (aw_cnt >= aw_dly);
  assign wready  = wvalid && (w_cnt >= w_dly);
  assign arready = arvalid && (ar_cnt >= ar_dly);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_hs_n <= 0; w_hs_n <= 0; b_hs_n <= 0;
      got_aw <= 0; got_w <= 0;
      bvalid <= 0; bresp <= 2'b00; rvalid <= 0; rresp <= 2'b00; rdata <= '0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      if (awvalid && awready) begin
        wr_addr_q.push_back(awaddr);
        aw_hs_n <= aw_hs_n + 1;
      end
      if (wvalid && wready) begin
        wr_data_q.push_back(wdata);
        w_hs_n <= w_hs_n + 1;
        check("wstrb", wstrb, 4'hF);
      end
      s_aw_now = got_aw || (awvalid && awready);
      s_w_now  = got_w || (wvalid && wready);
      if (bvalid && bready) begin
        bvalid <= 1'b0;
        b_hs_n <= b_hs_n + 1;
      end
      if (s_aw_now && s_w_now && !bvalid) begin
        s_inj = bresp_all || (rand_inj && ($urandom_range(0, 3) == 0));
        b_inj_q.push_back(s_inj);
        mem[wr_addr_q[$]] = wr_data_q[$];
        bvalid <= 1'b1;
        bresp  <= s_inj ? 2'b10 : 2'b00;
        got_aw <= 1'b0;
        got_w  <= 1'b0;
      end else begin
        got_aw <= s_aw_now;
        got_w  <= s_w_now;
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        s_d = mem.exists(araddr) ? mem[araddr] : 32'h0;
        if (rd_addr_q.size() == bad_idx) s_d = 32'hDEAD_BEEF;
        if (rand_inj && ($urandom_range(0, 3) == 0)) s_d = s_d ^ 32'h1;
        s_rinj = rand_inj && ($urandom_range(0, 3) == 0);
        rd_addr_q.push_back(araddr);
        r_data_q.push_back(s_d);
        r_inj_q.push_back(s_rinj);
        rvalid <= 1'b1;
        rdata  <= s_d;
        rresp  <= s_rinj ? 2'b10 : 2'b00;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bvalid1 <= 1'b0;
    else if (awvalid1) begin
      bvalid1 <= 1'b1;
      aw1_q.push_back(awaddr1);
      w1_q.push_back(wdata1);
    end else if (bvalid1 && bready1) bvalid1 <= 1'b0;
  end

  // Handshake rules observed mid-cycle against the previous cycle
  logic p_rst = 1'b0, p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0;
  logic p_arv = 1'b0, p_arr = 1'b0, p_bready = 1'b0;
  logic [31:0] p_awaddr, p_wdata, p_araddr;

  always @(negedge clk) begin
    if (rst_n && p_rst) begin
      if (p_awv && !p_awr) begin
        check("aw_hold", awvalid, 1);
        check("awaddr_stable", awaddr, p_awaddr);
      end
      if (p_awv && p_awr) check("aw_drop", awvalid, 0);
      if (p_wv && !p_wr) begin
        check("w_hold", wvalid, 1);
        check("wdata_stable", wdata, p_wdata);
      end
      if (p_wv && p_wr) check("w_drop", wvalid, 0);
      if (p_arv && !p_arr) begin
        check("ar_hold", arvalid, 1);
        check("araddr_stable", araddr, p_araddr);
      end
      if (bready && !p_bready) begin
        check("bready_after_aw", aw_hs_n - b_hs_n, 1);
        check("bready_after_w", w_hs_n - b_hs_n, 1);
      end
      if (arvalid1 || rready1) check("dut1_no_read", {arvalid1, rready1}, 2'b00);
    end
    p_rst = rst_n; p_awv = awvalid; p_awr = awready; p_wv = wvalid; p_wr = wready;
    p_arv = arvalid; p_arr = arready; p_bready = bready;
    p_awaddr = awaddr; p_wdata = wdata; p_araddr = araddr;
  end

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
    r_data_q.delete(); b_inj_q.delete(); r_inj_q.delete();
  endtask

  task automatic pulse_init();
    @(negedge clk) init = 1'b1;
    @(negedge clk) init = 1'b0;
  endtask

  task automatic run(input logic [1:0] m, input bit repulse);
    clear_logs();
    mode = m;
    pulse_init();
    check("start_done_clr", txn_done, 0);
    check("start_cnt_clr", err_count, 0);
    check("start_busy", busy, 1);
    if (repulse) begin
      repeat (5) @(negedge clk);
      pulse_init();
    end
    for (int c = 0; c < 400 && !txn_done; c++) @(negedge clk);
    check("run_done", txn_done, 1);
    check("run_busy_low", busy, 0);
  endtask

  // Reference: expected transaction lists and error count from the run rules
  task automatic verify(input logic [1:0] m);
    bit wr, rd;
    int exp_err;
    logic [31:0] a, d;
    wr = (m != 2'b10);
    rd = (m != 2'b01);
    exp_err = 0;
    check("n_writes", wr_addr_q.size(), wr ? N : 0);
    check("n_wdata", wr_data_q.size(), wr ? N : 0);
    check("n_reads", rd_addr_q.size(), rd ? N : 0);
    for (int i = 0; i < wr_addr_q.size() && i < wr_data_q.size(); i++) begin
      a = BASE + 32'(i) * STRIDE;
      d = SEED + 32'(i);
      check("wr_addr", wr_addr_q[i], a);
      check("wr_data", wr_data_q[i], d);
    end
    for (int i = 0; i < rd_addr_q.size(); i++)
      check("rd_addr", rd_addr_q[i], BASE + 32'(i) * STRIDE);
    foreach (b_inj_q[i]) if (b_inj_q[i]) exp_err++;
    foreach (r_data_q[i]) if (r_inj_q[i] || r_data_q[i] != SEED + 32'(i)) exp_err++;
    if (exp_err > 255) exp_err = 255;
    check("err_count", err_count, exp_err);
    check("error_flag", error, exp_err != 0);
    check("txn_done", txn_done, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_done", txn_done, 0);
    check("rst_error", error, 0);
    check("rst_cnt", err_count, 0);
    check("rst_busy", busy, 0);
    check("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
    check("rst_prot", {awprot, arprot}, 6'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run(2'b00, 0); verify(2'b00);

    aw_dly = 3;
    run(2'b00, 0); verify(2'b00);
    aw_dly = 0;

    bad_idx = 2;
    run(2'b00, 0); verify(2'b00);
    check("bad_read_cnt", err_count, 1);
    check("bad_read_err", error, 1);
    bad_idx = -1;

    run(2'b00, 0); verify(2'b00);
    check("restart_cnt", err_count, 0);

    bresp_all = 1;
    run(2'b01, 0); verify(2'b01);
    check("slverr_cnt", err_count, 4);
    check("slverr_no_ar", rd_addr_q.size(), 0);
    bresp_all = 0;

    run(2'b00, 0); verify(2'b00);
    run(2'b00, 1); verify(2'b00);

    clear_logs();
    mode = 2'b00;
    pulse_init();
    for (int c = 0; c < 20 && !awvalid; c++) @(negedge clk);
    check("midrst_awvalid_seen", awvalid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_aw_w", {awvalid, wvalid}, 2'b00);
    check("midrst_done", txn_done, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    run(2'b00, 0); verify(2'b00);

    run(2'b10, 0); verify(2'b10);
    run(2'b11, 0); verify(2'b11);

    rand_inj = 1;
    for (int it = 0; it < 10; it++) begin
      mode = 2'($urandom_range(0, 3));
      aw_dly = $urandom_range(0, 2);
      w_dly = $urandom_range(0, 2);
      ar_dly = $urandom_range(0, 2);
      run(mode, 0);
      verify(mode);
    end
    rand_inj = 0; aw_dly = 0; w_dly = 0; ar_dly = 0;

    @(negedge clk) init1 = 1'b1;
    @(negedge clk) init1 = 1'b0;
    for (int c = 0; c < 100 && !txn_done1; c++) @(negedge clk);
    check("wrap_done", txn_done1, 1);
    check("wrap_n", aw1_q.size(), 2);
    for (int i = 0; i < aw1_q.size(); i++) begin
      check("wrap_addr", aw1_q[i], (64'hFFFF_FFFC + 64'(i) * 4) % 64'h1_0000_0000);
      check("wrap_data", w1_q[i], SEED + 32'(i));
    end
    check("wrap_err", {error1, err_count1}, 9'd0);
    check("wrap_busy", busy1, 0);
    check("wrap_sideband", {wstrb1, awprot1, arprot1}, 10'h3C0);
    check("wrap_araddr_idx0", araddr1, 32'hFFFF_FFFC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
